// File: rtl/amber128_capfile_mp.sv
// Multi-port capability register file with optional null entry 0 and a tag-sweep revocation engine.
// Define AMBER128_CAPFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module amber128_capfile_mp #(
  parameter int unsigned DEPTH    = 32,   // CAP_REG_COUNT
  parameter int unsigned WIDTH    = 128,  // C_XLEN
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*AW-1:0]     waddr_i,
  input  logic [NUM_WR*WIDTH-1:0]  wdata_i,
  input  logic [NUM_WR-1:0]        wtag_i,
  input  logic [NUM_RD*AW-1:0]     raddr_i,
  output logic [NUM_RD*WIDTH-1:0]  rdata_o,
  output logic [NUM_RD-1:0]        rtag_o,
  input  logic                     sweep_req_i,
  output logic                     sweep_busy_o,
  output logic                     sweep_done_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0] mem_tag;
  logic [1:0]       state;
  logic [AW-1:0]    ptr;

  logic [DEPTH-1:0] wr_hit;
  logic [WIDTH-1:0] wr_data [DEPTH];
  logic [DEPTH-1:0] wr_tag;

  // Resolve all write ports per entry; ascending port order lets the highest port win.
  always_comb begin
    wr_hit = '0;
    wr_tag = '0;
    for (int unsigned e = 0; e < DEPTH; e++) wr_data[e] = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (we_i[p]) begin
        wr_hit[waddr_i[p*AW +: AW]]  = 1'b1;
        wr_data[waddr_i[p*AW +: AW]] = wdata_i[p*WIDTH +: WIDTH];
        wr_tag[waddr_i[p*AW +: AW]]  = wtag_i[p];
      end
    end
    if (ZERO_REG) begin
      wr_hit[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned e = 0; e < DEPTH; e++) mem_data[e] <= '0;
      mem_tag <= '0;
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (wr_hit[e]) begin
          mem_data[e] <= wr_data[e];
          mem_tag[e]  <= wr_tag[e];
        end else if (state == ST_SWEEP && ptr == AW'(e)) begin
          mem_tag[e] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sweep_req_i) begin
            state <= ST_SWEEP;
            ptr   <= '0;
          end
        end
        ST_SWEEP: begin
          if (ptr == AW'(DEPTH - 1)) begin
            state <= ST_DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign sweep_busy_o = (state == ST_SWEEP) || (state == ST_DONE);
  assign sweep_done_o = (state == ST_DONE);

  always_comb begin
    rdata_o = '0;
    rtag_o  = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rdata_o[r*WIDTH +: WIDTH] = mem_data[raddr_i[r*AW +: AW]];
      rtag_o[r]                 = mem_tag[raddr_i[r*AW +: AW]];
`ifdef AMBER128_CAPFILE_BYPASS_EN
      // Sweep clears are not forwarded; only the resolved write is.
      if (wr_hit[raddr_i[r*AW +: AW]]) begin
        rdata_o[r*WIDTH +: WIDTH] = wr_data[raddr_i[r*AW +: AW]];
        rtag_o[r]                 = wr_tag[raddr_i[r*AW +: AW]];
      end
`endif
      if (ZERO_REG && raddr_i[r*AW +: AW] == '0) begin
        rdata_o[r*WIDTH +: WIDTH] = '0;
        rtag_o[r]                 = 1'b0;
      end
    end
  end

endmodule
